outlier_collector: RTL and testbench
====================================

Name: outlier_collector

Overview:
- Collects outlier point indices from the CORE_NUMBER DROR filter cores and buffers them in a first-word-fall-through FIFO.
- Sits between the per-core outlier outputs and the BRAM write-back stage. That stage drains it with read_fifo, outlier_pos_fifo and empty, and zeroes each listed point in the x/y/z BRAMs.
- Arbitrates simultaneous core requests round-robin, one index per cycle.
- Keeps an accepted-outlier total for software.

Parameters:
- N, 16, width of one point index.
- CORE_NUMBER, 8, number of requesting cores (2..16).
- DEPTH, 64, FIFO entries; power of two.
- ADDR_W, 6, log2(DEPTH).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush at the start of each new point cloud.
- in_valid  in  CORE_NUMBER  per-core request; bit i belongs to core i.
- in_pos  in  N*CORE_NUMBER  per-core outlier index; core i uses bits [N*i+N-1:N*i].
- in_ready  out  CORE_NUMBER  one-hot grant, combinational from in_valid, rr_ptr and full.
- read_fifo  in  1  pop the head entry.
- outlier_pos_fifo  out  N  head entry; 0 when empty.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- count  out  ADDR_W+1  current occupancy.
- total_count  out  32  indices accepted since the last reset or clear; saturates at 0xFFFFFFFF.

Behaviour:
- Reset (async, immediate):
  - wr_ptr=rd_ptr=0, count=0, empty=1, full=0.
  - total_count=0, rr_ptr=0, in_ready=0, outlier_pos_fifo=0.
  - FIFO memory contents are don't-care.
- Clear (synchronous): same state as reset, at the next edge.
  - Has priority over any write or pop in the same cycle; those are discarded.
  - in_ready is forced to 0 while clear=1.
- Handshake:
  - A core holds in_valid[i] and its in_pos slice stable until it samples in_ready[i]=1.
  - A transfer happens on a rising edge with in_valid[i]&in_ready[i].
  - A core may deassert in_valid only after a transfer.
- Arbitration:
  - in_ready is all zero when full=1 or clear=1.
  - Otherwise grant goes to the first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod CORE_NUMBER.
  - On a grant to core g: rr_ptr <= (g+1) mod CORE_NUMBER.
  - With no grant, rr_ptr is unchanged.
  - At most one write per cycle.
- Write: mem[wr_ptr] <= granted in_pos slice; wr_ptr <= wr_ptr+1, wrapping mod DEPTH.
- Pop: accepted when read_fifo=1 and empty=0; rd_ptr <= rd_ptr+1, wrapping mod DEPTH.
  - read_fifo while empty is ignored, with no pointer or count change.
- Latency: an index granted at edge t appears on outlier_pos_fifo with empty=0 after edge t (FWFT, one cycle write-to-visible).
- Head output: outlier_pos_fifo = mem[rd_ptr] when !empty, else 0.
  - It updates to the next entry after the edge on which a pop is accepted.
- Simultaneous write and pop:
  - count unchanged.
  - Both pointers advance.
  - Valid for count 1..DEPTH-1.
- Write while empty: the same-cycle read_fifo is ignored; the count becomes 1.
- Full: writes are blocked even if a pop happens in the same cycle. in_ready reopens the cycle after count drops below DEPTH.
- count and flags:
  - count += write - pop, in the range 0..DEPTH.
  - empty and full are registered-equivalent functions of count, with no glitch path from inputs.
- total_count: +1 per accepted write; holds at 0xFFFFFFFF once reached.
- Order: FIFO order equals grant order. Indices are passed unmodified; no de-duplication.

Test Plan:
- Reset mid-operation: fill 5 entries, assert reset between edges -> empty=1, count=0, total_count=0 and outlier_pos_fifo=0 immediately; no pops produce data afterward.
- Single core: core 3 sends 0x0011 then 0x0022, read_fifo held high -> outputs 0x0011 then 0x0022; each visible one cycle after its grant; empty=1 at the end; total_count=2.
- Round robin: all 8 cores request continuously with in_pos=i, starting at rr_ptr=0 -> grants 0,1,...,7,0,... one per cycle; FIFO order 0..7; no core starved.
- Full: no pops and 70 requests -> full=1 at count=64 and in_ready=0; a pop together with a pending request -> no write that cycle, write on the next cycle; count returns to 64.
- Wrap-around: 100 pushes/pops interleaved at occupancy 1..3 -> data order preserved across pointer wrap; count never exceeds 3.
- Clear with pending ops: at count=4, assert clear along with read_fifo=1 and in_valid=0xFF -> count=0, empty=1, total_count=0, no write accepted; next request granted to core 0.

Source files
------------

// File: rtl/outlier_collector_if.sv
// Handshake bundle between the DROR cores, the outlier collector and the BRAM write-back stage.
// Ports: in_valid/in_pos/in_ready form the per-core request side; read_fifo/outlier_pos_fifo/empty
// form the drain side; full/count/total_count are status. master = cores + drain, slave = collector.
interface outlier_collector_if #(
  parameter int N           = 16,
  parameter int CORE_NUMBER = 8,
  parameter int ADDR_W      = 6
);
  logic [CORE_NUMBER-1:0]   in_valid;
  logic [N*CORE_NUMBER-1:0] in_pos;
  logic [CORE_NUMBER-1:0]   in_ready;
  logic                     read_fifo;
  logic [N-1:0]             outlier_pos_fifo;
  logic                     empty;
  logic                     full;
  logic [ADDR_W:0]          count;
  logic [31:0]              total_count;

  modport master (
    output in_valid, in_pos, read_fifo,
    input  in_ready, outlier_pos_fifo, empty, full, count, total_count
  );

  modport slave (
    input  in_valid, in_pos, read_fifo,
    output in_ready, outlier_pos_fifo, empty, full, count, total_count
  );
endinterface

// File: rtl/outlier_collector.sv
// Collects outlier point indices from the DROR cores into a first-word-fall-through FIFO,
// granting one core per cycle round-robin; keeps a saturating accepted-index total.
// Latency: an index granted on edge t is at the head after edge t. Backpressure: in_ready all
// zero while full or clear. Ports: clock, reset (async, high), clear (sync flush), bus (slave side).
module outlier_collector #(
  parameter int N           = 16,
  parameter int CORE_NUMBER = 8,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 6
) (
  input logic                clock,
  input logic                reset,
  input logic                clear,
  outlier_collector_if.slave bus
);

  localparam int              CW      = $clog2(CORE_NUMBER);
  localparam logic [CW:0]     CN_C    = (CW+1)'(CORE_NUMBER);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [N-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [31:0]       total_count;
  logic [CW-1:0]     rr_ptr;

  logic              empty;
  logic              full;
  logic              grant_vld;
  logic [CW-1:0]     grant_idx;
  logic [CW:0]       idxw;
  logic [CW:0]       rr_sum;
  logic [CW-1:0]     rr_nxt;
  logic              wr_en;
  logic              pop_en;
  logic [N-1:0]      wr_dat;

  // Flags derive from the count register only, so no input can glitch them.
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // Round-robin search: walk from the highest offset down so the lowest offset from rr_ptr
  // (the first requester at or after rr_ptr) is the one left standing.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idxw      = '0;
    for (int j = CORE_NUMBER - 1; j >= 0; j--) begin
      idxw = {1'b0, rr_ptr} + (CW+1)'(j);
      if (idxw >= CN_C) idxw = idxw - CN_C;
      if (bus.in_valid[idxw[CW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idxw[CW-1:0];
      end
    end
    // A full FIFO blocks writes even when a pop is accepted in the same cycle.
    if (full || clear || reset) grant_vld = 1'b0;
  end

  always_comb begin
    rr_sum = {1'b0, grant_idx} + (CW+1)'(1);
    if (rr_sum == CN_C) rr_sum = '0;
    rr_nxt = rr_sum[CW-1:0];
  end

  assign wr_en  = grant_vld;
  assign pop_en = bus.read_fifo && !empty && !clear;
  assign wr_dat = bus.in_pos[grant_idx*N +: N];

  assign bus.in_ready         = grant_vld ? (CORE_NUMBER'(1) << grant_idx) : '0;
  assign bus.outlier_pos_fifo = empty ? '0 : mem[rd_ptr];
  assign bus.empty            = empty;
  assign bus.full             = full;
  assign bus.count            = count;
  assign bus.total_count      = total_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      total_count <= '0;
      rr_ptr      <= '0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      total_count <= '0;
      rr_ptr      <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        rr_ptr <= rr_nxt;
        if (total_count != 32'hFFFF_FFFF) total_count <= total_count + 32'd1;
      end
      if (pop_en) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_en, pop_en})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only visible through rd_ptr while count is nonzero.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: tb/tb_outlier_collector.sv
module tb_outlier_collector;
  localparam int N     = 16;
  localparam int NC    = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic clock = 1'b0;
  logic reset;
  logic clear;

  always #5 clock = ~clock;

  outlier_collector_if #(.N(N), .CORE_NUMBER(NC), .ADDR_W(AW)) bus ();

  outlier_collector #(.N(N), .CORE_NUMBER(NC), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  // Reference model: queue contents, saturating total, round-robin start point.
  logic [N-1:0] q[$];
  logic [31:0]  m_total;
  int           m_rr;
  bit           pend [NC];
  logic [N-1:0] pv   [NC];
  int           n_checks;
  int           n_pass;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic drive(input bit rd, input bit clr);
    for (int c = 0; c < NC; c++) begin
      bus.in_valid[c]          = pend[c];
      bus.in_pos[c*N +: N]     = pv[c];
    end
    bus.read_fifo = rd;
    clear         = clr;
  endtask

  function automatic int model_grant(input bit clr);
    if (clr || q.size() == DEPTH) return -1;
    for (int k = 0; k < NC; k++) begin
      if (pend[(m_rr + k) % NC]) return (m_rr + k) % NC;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    check_val("head",  32'(bus.outlier_pos_fifo), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    check_val("empty", 32'(bus.empty), 32'(q.size() == 0));
    check_val("full",  32'(bus.full),  32'(q.size() == DEPTH));
    check_val("count", 32'(bus.count), 32'(q.size()));
    check_val("total", bus.total_count, m_total);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic tick(input bit rd, input bit clr);
    int          g;
    logic [NC-1:0] exp_rdy;
    drive(rd, clr);
    #1;
    g = model_grant(clr);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_val("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clock);
    if (clr) begin
      q.delete();
      m_total = 0;
      m_rr    = 0;
    end else begin
      if (rd && q.size() > 0) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back(pv[g]);
        pend[g] = 1'b0;
        m_rr    = (g + 1) % NC;
        if (m_total != 32'hFFFF_FFFF) m_total++;
      end
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic refill(input int pct);
    for (int c = 0; c < NC; c++) begin
      if (!pend[c] && ($urandom_range(99) < pct)) begin
        pend[c] = 1'b1;
        pv[c]   = N'($urandom);
      end
    end
  endtask

  task automatic drop_all();
    for (int c = 0; c < NC; c++) pend[c] = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_total  = 0;
    m_rr     = 0;
    drop_all();
    for (int c = 0; c < NC; c++) pv[c] = '0;
    reset = 1'b1;
    drive(0, 0);

    // Reset state, with a request present: nothing may be granted.
    pend[2] = 1'b1;
    drive(0, 0);
    @(negedge clock);
    check_outputs();
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
    pend[2] = 1'b0;
    drive(0, 0);
    reset = 1'b0;

    // Single core 3: 0x0011 then 0x0022, drain held high.
    pend[3] = 1'b1; pv[3] = 16'h0011;
    tick(1, 0);
    check_val("sc_first", 32'(bus.outlier_pos_fifo), 32'h0011);
    pend[3] = 1'b1; pv[3] = 16'h0022;
    tick(1, 0);
    check_val("sc_second", 32'(bus.outlier_pos_fifo), 32'h0022);
    tick(1, 0);
    tick(1, 0);
    check_val("sc_total", bus.total_count, 32'd2);

    // Round robin: everyone requests continuously with in_pos = core number.
    tick(0, 1);
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < NC; c++) begin
        pend[c] = 1'b1;
        pv[c]   = N'(c);
      end
      tick(1, 0);
    end

    // Full: no pops, 70 requests.
    tick(0, 1);
    drop_all();
    for (int i = 0; i < 70; i++) begin
      refill(100);
      tick(0, 0);
    end
    check_val("full_count", 32'(bus.count), 32'(DEPTH));
    refill(100);
    tick(1, 0);
    tick(0, 0);
    check_val("full_refill", 32'(bus.count), 32'(DEPTH));

    // Wrap-around at low occupancy.
    tick(0, 1);
    drop_all();
    for (int i = 0; i < 100; i++) begin
      refill(60);
      tick((q.size() >= 3) ? 1'b1 : 1'(($urandom % 2)), 0);
      check_val("occ_le3", 32'(bus.count <= 3), 32'd1);
    end

    // Clear racing a pop and a full request vector at count 4.
    tick(0, 1);
    drop_all();
    for (int i = 0; i < 4; i++) begin
      pend[$urandom_range(NC-1)] = 1'b1;
      tick(0, 0);
      drop_all();
    end
    check_val("clr_pre_count", 32'(bus.count), 32'd4);
    for (int c = 0; c < NC; c++) begin
      pend[c] = 1'b1;
      pv[c]   = N'($urandom);
    end
    tick(1, 1);
    tick(0, 0);
    check_val("clr_next_grant_pos", 32'(bus.outlier_pos_fifo), 32'(pv[0]));

    // Reset mid-operation after five entries.
    tick(0, 1);
    drop_all();
    for (int i = 0; i < 5; i++) begin
      pend[i] = 1'b1;
      pv[i]   = N'($urandom);
      tick(0, 0);
    end
    pend[6] = 1'b1;
    drive(0, 0);
    #2 reset = 1'b1;
    #1;
    q.delete();
    m_total = 0;
    m_rr    = 0;
    check_outputs();
    check_val("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    drop_all();
    for (int i = 0; i < 3; i++) tick(1, 0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      refill(30);
      tick(1'($urandom % 2), ($urandom_range(199) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
